eth_phy_10g_rx_slip_aligner: RTL and testbench
==============================================

ETH_PHY_10G_RX_SLIP_ALIGNER -- requirements
Module: eth_phy_10g_rx_slip_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width of one 66-bit block.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync-header width.
REQ-003 SHALL have parameter SLIP_GUARD_CYCLES, default 8, cycles after an accepted slip during which further slip requests are ignored.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: rx_clk and rx_rst. rx_rst=0 resets the block immediately.
REQ-005 SHALL have port rx_clk  input  1  rx word clock.
REQ-006 SHALL have port rx_rst  input  1  asynchronous reset, active-low.
REQ-007 SHALL have port raw_data  input  66  unaligned SERDES word; bit 0 is received first.
REQ-008 SHALL have port raw_valid  input  1  raw_data is valid this cycle.
REQ-009 SHALL have port bitslip  input  1  slip request from the frame-sync stage (serdes_rx_bitslip); level, possibly multi-cycle.
REQ-010 SHALL have port serdes_rx_data  output  64  aligned block payload.
REQ-011 SHALL have port serdes_rx_hdr  output  2  aligned sync header.
REQ-012 SHALL have port out_valid  output  1  serdes_rx_data/serdes_rx_hdr are valid.
REQ-013 SHALL have port slip_offset  output  7  current bit offset, 0..65.
REQ-014 SHALL have port slip_busy  output  1  high while a guard interval is active.

Function
REQ-015 SHALL keep a 132-bit window W = {raw_cur, raw_prev}, with raw_prev in W[65:0]. The window SHALL advance only on cycles with raw_valid=1.
REQ-016 SHALL form the aligned block B = W[slip_offset+65 : slip_offset], with serdes_rx_hdr = B[1:0] and serdes_rx_data = B[65:2].
REQ-017 SHALL register outputs with a latency of exactly 1 cycle: a raw_valid word at edge N produces out_valid at edge N+1.
REQ-018 SHALL implement an FSM with states PRIME, RUN and GUARD.
- PRIME is the reset state. On the first raw_valid word it loads raw_prev and goes to RUN. No out_valid is produced from PRIME.
- In RUN, an accepted slip goes to GUARD.
- In GUARD, the guard counter loads SLIP_GUARD_CYCLES-1 on entry and decrements every cycle. At 0 the FSM returns to RUN.
REQ-019 SHALL accept a slip only on a 0->1 edge of bitslip while in RUN. Edges in PRIME or GUARD, and bitslip held high, SHALL be ignored.
REQ-020 SHALL apply an accepted slip as slip_offset+1 at the following edge, independent of raw_valid.
REQ-021 SHALL wrap slip_offset from 65 to 0. On wrap, the next raw_valid word SHALL be consumed without asserting out_valid (exactly one suppressed output), so stream continuity equals offset 66.
REQ-022 SHALL drive out_valid=0 on every cycle following raw_valid=0; serdes_rx_data/serdes_rx_hdr SHALL hold their last values.
REQ-023 SHALL drive slip_busy=1 exactly while the FSM is in GUARD.
REQ-024 SHALL, when a slip edge and raw_valid=1 coincide in RUN, output the current word with the old offset; the new offset applies from the next word.

Reset
REQ-025 SHALL, while rx_rst=0, force serdes_rx_data=0, serdes_rx_hdr=0, out_valid=0, slip_offset=0, slip_busy=0, FSM=PRIME, guard counter=0, window=0 and the bitslip edge register=0.
REQ-026 SHALL, on reset assertion mid-operation (including in GUARD or with a pending wrap), discard all state; after release, the first raw_valid word again only primes.
REQ-027 SHALL synchronise reset release to rx_clk; the reset assertion path SHALL remain asynchronous.

Verification
REQ-028 SHALL cover misalignment search: a continuous stream of blocks with hdr=2'b01 and incrementing payload, shifted by 5 bits, plus 5 spaced single-cycle bitslip pulses -> slip_offset=5, then serdes_rx_hdr=2'b01 and payload increments by 1 per out_valid.
REQ-029 SHALL cover wrap: 66 accepted slips on an aligned stream -> slip_offset returns to 0, out_valid is low for exactly one word, and the payload sequence continues without duplication.
REQ-030 SHALL cover guard: a bitslip pulse, then another pulse 3 cycles later with SLIP_GUARD_CYCLES=8 -> only one increment, and slip_busy is high for 8 cycles.
REQ-031 SHALL cover held level: bitslip high for 4 cycles -> slip_offset increments by exactly 1.
REQ-032 SHALL cover valid gaps: raw_valid toggling 1,0,1 -> out_valid is 1,0,1 one cycle later, with data held during the gap.
REQ-033 SHALL cover reset mid-guard: rx_rst=0 asserted during GUARD -> all outputs 0 immediately; after release, out_valid first rises on the second valid word.

Source files
------------

// File: rtl/eth_phy_10g_rx_slip_aligner.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_rx_slip_aligner
//
// Purpose: recovers 66-bit block alignment from an unaligned SERDES word
// stream. A 132-bit window {current word, previous word} is kept and the
// aligned block is cut out of it at bit position slip_offset. Each rising
// edge of the frame-sync stage's bitslip request moves the cut point one bit
// later in the stream. A guard interval then blocks further slips until the
// change has had time to show up at the frame-sync stage.
//
// Ports:
//   rx_clk          in   rx word clock
//   rx_rst          in   asynchronous reset, active-low (release synchronised)
//   raw_data        in   unaligned SERDES word, bit 0 received first
//   raw_valid       in   raw_data is valid this cycle
//   bitslip         in   slip request level; only a 0->1 edge in RUN counts
//   serdes_rx_data  out  aligned block payload (block bits 65:2)
//   serdes_rx_hdr   out  aligned sync header   (block bits 1:0)
//   out_valid       out  serdes_rx_data/serdes_rx_hdr carry a new block
//   slip_offset     out  current bit offset into the window, 0..65
//   slip_busy       out  high while the slip guard interval runs
//   dbg_state       out  FSM state (0 PRIME, 1 RUN, 2 GUARD)
//
// Valid semantics: there is no back-pressure. out_valid is high for exactly
// one cycle per emitted block; when it is low the data/hdr outputs hold the
// last emitted block.
// -----------------------------------------------------------------------------
module eth_phy_10g_rx_slip_aligner #(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int SLIP_GUARD_CYCLES = 8
) (
    input  logic                            rx_clk,
    input  logic                            rx_rst,
    input  logic [DATA_WIDTH+HDR_WIDTH-1:0] raw_data,
    input  logic                            raw_valid,
    input  logic                            bitslip,
    output logic [DATA_WIDTH-1:0]           serdes_rx_data,
    output logic [HDR_WIDTH-1:0]            serdes_rx_hdr,
    output logic                            out_valid,
    output logic [6:0]                      slip_offset,
    output logic                            slip_busy,
    output logic [1:0]                      dbg_state
);

    localparam int BW = DATA_WIDTH + HDR_WIDTH;
    localparam int OW = 7;
    localparam int IW = $clog2(2 * BW);
    localparam int GW = (SLIP_GUARD_CYCLES > 1) ? $clog2(SLIP_GUARD_CYCLES) : 1;
    localparam logic [OW-1:0] OFF_MAX    = OW'(BW - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(SLIP_GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // Reset release synchroniser: assertion passes straight through the
    // asynchronous clear, release takes two rx_clk edges.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_e                  state_q, state_d;
    logic [GW-1:0]           guard_q, guard_d;
    logic                    bitslip_q;
    logic [BW-1:0]           prev_q;
    logic [OW-1:0]           offset_q;
    logic                    skip_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [HDR_WIDTH-1:0]    hdr_q;

    logic                    slip_edge;
    logic                    slip_accept;
    logic                    emit;
    logic [2*BW-1:0]         window;
    logic [IW-1:0]           win_idx;
    logic [BW-1:0]           blk;

    assign slip_edge = bitslip & ~bitslip_q;
    assign window    = {raw_data, prev_q};
    assign win_idx   = IW'(offset_q);
    assign blk       = window[win_idx +: BW];

    // FSM: state register
    always_ff @(posedge rx_clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_PRIME;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_PRIME: begin
                if (raw_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (slip_edge) begin
                    state_d = ST_GUARD;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (guard_q == '0) state_d = ST_RUN;
                else               guard_d = guard_q - 1'b1;
            end
            default: begin
                state_d = ST_PRIME;
                guard_d = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        slip_accept = 1'b0;
        emit        = 1'b0;
        slip_busy   = 1'b0;
        case (state_q)
            ST_RUN: begin
                slip_accept = slip_edge;
                emit        = raw_valid & ~skip_q;
            end
            ST_GUARD: begin
                emit      = raw_valid & ~skip_q;
                slip_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. The word arriving with an accepted slip is still cut with the
    // old offset because blk reads offset_q before it updates.
    always_ff @(posedge rx_clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            bitslip_q   <= 1'b0;
            prev_q      <= '0;
            offset_q    <= '0;
            skip_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            hdr_q       <= '0;
        end else begin
            bitslip_q   <= bitslip;
            out_valid_q <= emit;
            if (raw_valid) prev_q <= raw_data;
            if (emit) begin
                data_q <= blk[BW-1:HDR_WIDTH];
                hdr_q  <= blk[HDR_WIDTH-1:0];
            end
            if (slip_accept) begin
                offset_q <= (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;
            end
            // Wrapping from the last offset to 0 is equivalent to moving one
            // whole word ahead, so the next valid word is dropped.
            if (slip_accept && offset_q == OFF_MAX) begin
                skip_q <= 1'b1;
            end else if (raw_valid && state_q != ST_PRIME) begin
                skip_q <= 1'b0;
            end
        end
    end

    assign serdes_rx_data = data_q;
    assign serdes_rx_hdr  = hdr_q;
    assign out_valid      = out_valid_q;
    assign slip_offset    = offset_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_slip_aligner.sv
module tb_eth_phy_10g_rx_slip_aligner;

  localparam int BW = 66;
  localparam int G  = 8;

  // clock / reset
  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [65:0] raw_data = '0;
  logic        raw_valid = 1'b0;
  logic        bitslip = 1'b0;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic        out_valid;
  logic [6:0]  slip_offset;
  logic        slip_busy;
  logic [1:0]  dbg_state;

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_rx_slip_aligner #(
    .DATA_WIDTH(64),
    .HDR_WIDTH(2),
    .SLIP_GUARD_CYCLES(G)
  ) dut (
    .rx_clk(rx_clk),
    .rx_rst(rx_rst),
    .raw_data(raw_data),
    .raw_valid(raw_valid),
    .bitslip(bitslip),
    .serdes_rx_data(serdes_rx_data),
    .serdes_rx_hdr(serdes_rx_hdr),
    .out_valid(out_valid),
    .slip_offset(slip_offset),
    .slip_busy(slip_busy),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the received words form one bit stream; an emitted block
  // is simply 66 consecutive stream bits starting at 66*(k-1)+offset.
  // ---------------------------------------------------------------------------
  logic [65:0] m_words[$];
  bit          m_primed;
  int          m_off;
  bit          m_skip;
  int          m_busy_left;
  bit          m_last_bs;
  bit          m_ov;
  logic [63:0] m_data;
  logic [1:0]  m_hdr;

  function automatic logic [65:0] stream_blk(int p);
    logic [65:0] r;
    logic [65:0] w;
    int q;
    for (int i = 0; i < BW; i++) begin
      q = p + i;
      w = m_words[q / BW];
      r[i] = w[q % BW];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_primed = 0;
    m_off = 0;
    m_skip = 0;
    m_busy_left = 0;
    m_last_bs = 0;
    m_ov = 0;
    m_data = '0;
    m_hdr = '0;
  endtask

  task automatic model_edge(input bit v, input logic [65:0] d, input bit bs);
    bit rising;
    logic [65:0] b;
    int k;
    rising = bs && !m_last_bs;
    m_last_bs = bs;
    m_ov = 0;
    if (!m_primed) begin
      if (v) begin
        m_words.push_back(d);
        m_primed = 1;
      end
    end else begin
      if (v) begin
        m_words.push_back(d);
        k = m_words.size() - 1;
        if (m_skip) begin
          m_skip = 0;
        end else begin
          m_ov = 1;
          b = stream_blk(BW * (k - 1) + m_off);
          m_hdr = b[1:0];
          m_data = b[65:2];
        end
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (rising) begin
        m_busy_left = G;
        if (m_off == BW - 1) begin
          m_off = 0;
          m_skip = 1;
        end else begin
          m_off++;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("mdl_out_valid", 128'(out_valid), 128'(m_ov));
    check("mdl_slip_offset", 128'(slip_offset), 128'(m_off));
    check("mdl_slip_busy", 128'(slip_busy), 128'(m_busy_left > 0));
    check("mdl_hdr", 128'(serdes_rx_hdr), 128'(m_hdr));
    check("mdl_data", 128'(serdes_rx_data), 128'(m_data));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit v, input logic [65:0] d, input bit bs);
    raw_valid = v;
    raw_data = d;
    bitslip = bs;
    model_edge(v, d, bs);
    @(posedge rx_clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rx_rst = 1'b0;
    raw_valid = 1'b0;
    bitslip = 1'b0;
    #1;
    check("rst_data", 128'(serdes_rx_data), 128'(0));
    check("rst_hdr", 128'(serdes_rx_hdr), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_offset", 128'(slip_offset), 128'(0));
    check("rst_busy", 128'(slip_busy), 128'(0));
    model_reset();
    repeat (2) @(posedge rx_clk);
    #1;
    rx_rst = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0);
  endtask

  function automatic logic [65:0] blk_n(int n);
    logic [63:0] p;
    p = 64'(n);
    return {p, 2'b01};
  endfunction

  // Raw word j of a stream of blocks blk_n(0), blk_n(1), ... delayed by sh bits.
  function automatic logic [65:0] raw_word(int j, int sh);
    logic [65:0] r;
    logic [65:0] t;
    int q;
    for (int i = 0; i < BW; i++) begin
      q = BW * j + i - sh;
      if (q < 0) begin
        r[i] = 1'b0;
      end else begin
        t = blk_n(q / BW);
        r[i] = t[q % BW];
      end
    end
    return r;
  endfunction

  function automatic logic [65:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[65:0];
  endfunction

  int g_j;
  int g_sh;

  task automatic send(input bit v, input bit bs);
    cycle(v, raw_word(g_j, g_sh), bs);
    if (v) g_j++;
  endtask

  typedef struct {
    bit v;
    bit bs;
    bit exp_ov;
    int exp_off;
    bit exp_busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int busy_cnt;
    int ov_cnt;
    int jw;
    bit bs_r;

    tbl[0]  = '{0, 1, 0, 0, 0};  // edge while priming: ignored
    tbl[1]  = '{0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0};  // first valid word only primes
    tbl[3]  = '{1, 1, 1, 1, 1};  // edge in RUN: old offset for this word
    tbl[4]  = '{1, 1, 1, 1, 1};  // held level
    tbl[5]  = '{0, 0, 0, 1, 1};  // gap
    tbl[6]  = '{1, 1, 1, 1, 1};  // edge inside guard: ignored
    tbl[7]  = '{1, 0, 1, 1, 1};
    tbl[8]  = '{1, 0, 1, 1, 1};
    tbl[9]  = '{1, 0, 1, 1, 1};
    tbl[10] = '{1, 0, 1, 1, 1};  // eighth busy cycle
    tbl[11] = '{1, 1, 1, 1, 0};  // guard ends this edge: edge ignored
    tbl[12] = '{1, 1, 1, 1, 0};  // still held
    tbl[13] = '{1, 0, 1, 1, 0};
    tbl[14] = '{1, 1, 1, 2, 1};  // fresh edge in RUN accepted

    #1;
    do_reset();

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, rand_word(), tbl[i].bs);
      check($sformatf("tbl%0d_ov", i), 128'(out_valid), 128'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_off", i), 128'(slip_offset), 128'(tbl[i].exp_off));
      check($sformatf("tbl%0d_busy", i), 128'(slip_busy), 128'(tbl[i].exp_busy));
    end

    // misalignment search: stream delayed by 5 bits, five spaced pulses
    do_reset();
    g_j = 0;
    g_sh = 5;
    send(1, 0);
    for (int p = 0; p < 5; p++) begin
      send(1, 1);
      repeat (11) send(1, 0);
    end
    check("search_offset", 128'(slip_offset), 128'(5));
    for (int n = 0; n < 8; n++) begin
      send(1, 0);
      check("search_ov", 128'(out_valid), 128'(1));
      check("search_hdr", 128'(serdes_rx_hdr), 128'(2'b01));
      check("search_payload", 128'(serdes_rx_data), 128'(g_j - 2));
    end

    // wrap: 66 accepted slips on an aligned stream
    do_reset();
    g_j = 0;
    g_sh = 0;
    send(1, 0);
    send(1, 0);
    check("wrap_pre_payload", 128'(serdes_rx_data), 128'(0));
    for (int s = 0; s < BW; s++) begin
      send(1, 1);
      if (s < BW - 1) repeat (9) send(1, 0);
    end
    jw = g_j - 1;
    check("wrap_last_ov", 128'(out_valid), 128'(1));
    check("wrap_offset", 128'(slip_offset), 128'(0));
    send(1, 0);
    check("wrap_gap_ov", 128'(out_valid), 128'(0));
    send(1, 0);
    check("wrap_resume_ov", 128'(out_valid), 128'(1));
    check("wrap_resume_hdr", 128'(serdes_rx_hdr), 128'(2'b01));
    check("wrap_resume_payload", 128'(serdes_rx_data), 128'(jw + 1));
    send(1, 0);
    check("wrap_next_payload", 128'(serdes_rx_data), 128'(jw + 2));

    // guard: second pulse 3 cycles after the first
    do_reset();
    g_j = 0;
    g_sh = 0;
    send(1, 0);
    send(1, 0);
    busy_cnt = 0;
    send(1, 1);
    busy_cnt += int'(slip_busy);
    send(1, 0);
    busy_cnt += int'(slip_busy);
    send(1, 0);
    busy_cnt += int'(slip_busy);
    send(1, 1);
    busy_cnt += int'(slip_busy);
    for (int n = 0; n < 10; n++) begin
      send(1, 0);
      busy_cnt += int'(slip_busy);
    end
    check("guard_offset", 128'(slip_offset), 128'(1));
    check("guard_busy_cycles", 128'(busy_cnt), 128'(G));

    // held level for 4 cycles
    repeat (4) send(1, 1);
    repeat (10) send(1, 0);
    check("held_offset", 128'(slip_offset), 128'(2));

    // valid gaps 1,0,1
    do_reset();
    g_j = 0;
    g_sh = 0;
    send(1, 0);
    send(1, 0);
    check("gap_ov1", 128'(out_valid), 128'(1));
    check("gap_data1", 128'(serdes_rx_data), 128'(0));
    send(0, 0);
    check("gap_ov0", 128'(out_valid), 128'(0));
    check("gap_hold_data", 128'(serdes_rx_data), 128'(0));
    check("gap_hold_hdr", 128'(serdes_rx_hdr), 128'(2'b01));
    send(1, 0);
    check("gap_ov2", 128'(out_valid), 128'(1));
    check("gap_data2", 128'(serdes_rx_data), 128'(1));

    // reset during guard
    send(1, 1);
    check("rg_busy", 128'(slip_busy), 128'(1));
    send(1, 0);
    do_reset();
    send(1, 0);
    check("rg_prime_ov", 128'(out_valid), 128'(0));
    send(1, 0);
    check("rg_second_ov", 128'(out_valid), 128'(1));
    check("rg_payload", 128'(serdes_rx_data), 128'(g_j - 2));
    check("rg_offset", 128'(slip_offset), 128'(0));

    // randomized stimulus against the model
    do_reset();
    bs_r = 0;
    ov_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        bs_r = 0;
      end else begin
        if ($urandom_range(0, 3) == 0) bs_r = ~bs_r;
        cycle($urandom_range(0, 4) != 0, rand_word(), bs_r);
        ov_cnt += int'(out_valid);
      end
    end
    check("rand_some_output", 128'(ov_cnt > 100), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
